// File: rtl/mesa_ascii2byte_pkg.sv
// Shared types and constants for the Mesa ASCII-hex receive decoder.
package mesa_ascii2byte_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_SP = 8'h20;

    typedef enum logic [1:0] {
        ERR_OVERFLOW = 2'd0,
        ERR_BADCHAR  = 2'd1,
        ERR_ODDNIB   = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_t;

    // HI: a completed byte sits in the hold register, waiting for the next high nibble
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_DISCARD
    } state_t;

endpackage

// File: rtl/mesa_hex2nib.sv
// Combinational ASCII character classifier and hex-digit-to-nibble converter.
module mesa_hex2nib
    import mesa_ascii2byte_pkg::*;
(
    input  logic [7:0] char_d,
    output logic       is_hex,
    output logic       is_term,
    output logic       is_space,
    output logic [3:0] nib
);

    // Classify the char and convert hex digits; letters sit at offset 9 from their low bits
    always_comb begin
        is_hex   = 1'b0;
        nib      = '0;
        is_term  = (char_d == ASCII_LF) || (char_d == ASCII_CR);
        is_space = (char_d == ASCII_SP);
        if (char_d >= 8'h30 && char_d <= 8'h39) begin
            is_hex = 1'b1;
            nib    = char_d[3:0];
        end else if ((char_d >= 8'h41 && char_d <= 8'h46) ||
                     (char_d >= 8'h61 && char_d <= 8'h66)) begin
            is_hex = 1'b1;
            nib    = char_d[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/mesa_ascii2byte.sv
// Mesa Ro host receive decoder: ASCII hex chars in, framed binary bytes out.
module mesa_ascii2byte
    import mesa_ascii2byte_pkg::*;
#(
    parameter int unsigned MAX_BYTES   = 256,
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned LEN_W       = 9
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_char_en,
    input  logic [7:0]       rx_char_d,
    output logic             rx_byte_en,
    output logic [7:0]       rx_byte_d,
    output logic             rx_byte_sop,
    output logic             rx_byte_eop,
    output logic             rx_err_en,
    output logic [1:0]       rx_err_code,
    output logic [LEN_W-1:0] rx_pkt_len,
    output logic             rx_busy
);

    localparam int unsigned TMR_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    state_t             state_q, state_d;
    logic [3:0]         nib_q, nib_d;
    logic [7:0]         hold_q, hold_d;
    logic               hold_vld_q, hold_vld_d;
    logic               hold_sop_q, hold_sop_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               byte_en_d, sop_d, eop_d, err_en_d;
    logic [7:0]         byte_d_d;
    logic [1:0]         err_code_d;

    logic               is_hex, is_term, is_space;
    logic [3:0]         nib;
    logic               is_bad;

    mesa_hex2nib u_hex2nib (
        .char_d   (rx_char_d),
        .is_hex   (is_hex),
        .is_term  (is_term),
        .is_space (is_space),
        .nib      (nib)
    );

    assign is_bad  = !is_hex && !is_term && !is_space;
    assign rx_busy = (state_q != ST_IDLE);

    // Next-state, hold-back and strobe logic; a char and a timer expiry never coincide,
    // so at most one of byte/err strobes is raised per cycle
    always_comb begin
        state_d    = state_q;
        nib_d      = nib_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        hold_sop_d = hold_sop_q;
        len_d      = len_q;
        tmr_d      = '0;
        byte_en_d  = 1'b0;
        byte_d_d   = rx_byte_d;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        err_en_d   = 1'b0;
        err_code_d = rx_err_code;

        if (rx_char_en) begin
            if (is_bad && state_q != ST_DISCARD) begin
                err_en_d   = 1'b1;
                err_code_d = ERR_BADCHAR;
                hold_vld_d = 1'b0;
                state_d    = ST_DISCARD;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (is_hex) begin
                            nib_d   = nib;
                            len_d   = '0;
                            state_d = ST_LO;
                        end
                    end
                    ST_LO: begin
                        if (is_hex) begin
                            if (len_q == LEN_W'(MAX_BYTES)) begin
                                err_en_d   = 1'b1;
                                err_code_d = ERR_OVERFLOW;
                                hold_vld_d = 1'b0;
                                state_d    = ST_DISCARD;
                            end else begin
                                if (hold_vld_q) begin
                                    byte_en_d = 1'b1;
                                    byte_d_d  = hold_q;
                                    sop_d     = hold_sop_q;
                                end
                                hold_d     = {nib_q, nib};
                                hold_vld_d = 1'b1;
                                hold_sop_d = !hold_vld_q;
                                len_d      = len_q + LEN_W'(1);
                                state_d    = ST_HI;
                            end
                        end else if (is_term) begin
                            err_en_d   = 1'b1;
                            err_code_d = ERR_ODDNIB;
                            hold_vld_d = 1'b0;
                            state_d    = ST_IDLE;
                        end
                    end
                    ST_HI: begin
                        if (is_hex) begin
                            nib_d   = nib;
                            state_d = ST_LO;
                        end else if (is_term) begin
                            byte_en_d  = 1'b1;
                            byte_d_d   = hold_q;
                            sop_d      = hold_sop_q;
                            eop_d      = 1'b1;
                            hold_vld_d = 1'b0;
                            state_d    = ST_IDLE;
                        end
                    end
                    ST_DISCARD: begin
                        if (is_term) state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if ((state_q == ST_LO || state_q == ST_HI) && TIMEOUT_CYC != 0) begin
            tmr_d = tmr_q + TMR_W'(1);
            if (tmr_d == TMR_W'(TIMEOUT_CYC)) begin
                tmr_d      = '0;
                err_en_d   = 1'b1;
                err_code_d = ERR_TIMEOUT;
                hold_vld_d = 1'b0;
                state_d    = ST_IDLE;
            end
        end
    end

    // State, datapath and registered output strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            nib_q       <= '0;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            hold_sop_q  <= 1'b0;
            len_q       <= '0;
            tmr_q       <= '0;
            rx_byte_en  <= 1'b0;
            rx_byte_d   <= '0;
            rx_byte_sop <= 1'b0;
            rx_byte_eop <= 1'b0;
            rx_err_en   <= 1'b0;
            rx_err_code <= '0;
        end else begin
            state_q     <= state_d;
            nib_q       <= nib_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            hold_sop_q  <= hold_sop_d;
            len_q       <= len_d;
            tmr_q       <= tmr_d;
            rx_byte_en  <= byte_en_d;
            rx_byte_d   <= byte_d_d;
            rx_byte_sop <= sop_d;
            rx_byte_eop <= eop_d;
            rx_err_en   <= err_en_d;
            rx_err_code <= err_code_d;
        end
    end

    assign rx_pkt_len = len_q;

endmodule
